// File: rtl/rot_merge_pkg.sv
// Shared types and helpers for the rotate-and-merge pipeline.
// Optional build macro: ROT_MERGE_ZERO_EN (adds out_zero flag).
package rot_merge_pkg;

    localparam int WORD_W  = 32;
    localparam int SHIFT_W = 5;

    typedef struct packed {
        logic [WORD_W-1:0] rot;
        logic [WORD_W-1:0] a;
        logic [WORD_W-1:0] msk;
        logic              valid;
    } s1_t;

    // Mask selects rotated bits; clear mask bits keep the A-side word.
    function automatic logic [WORD_W-1:0] merge(input s1_t s);
        return (s.rot & s.msk) | (s.a & ~s.msk);
    endfunction

endpackage

// File: rtl/rot_merge_rotator.sv
// Stateless 5-level barrel rotator: rotates data_i left by shamt_i.
// Level k rotates by 2**k when shamt_i[k] is set.
module rot_merge_rotator
    import rot_merge_pkg::*;
(
    input  logic [WORD_W-1:0]  data_i,
    input  logic [SHIFT_W-1:0] shamt_i,
    output logic [WORD_W-1:0]  data_o
);

    logic [WORD_W-1:0] lvl [0:SHIFT_W];

    assign lvl[0] = data_i;

    for (genvar k = 0; k < SHIFT_W; k++) begin : g_lvl
        localparam int N = 1 << k;
        assign lvl[k+1] = shamt_i[k]
            ? {lvl[k][WORD_W-N-1:0], lvl[k][WORD_W-1:WORD_W-N]}
            : lvl[k];
    end

    assign data_o = lvl[SHIFT_W];

endmodule

// File: rtl/rot_merge.sv
// Two-stage rotate/mask-merge pipeline with valid/ready handshakes.
// Define ROT_MERGE_ZERO_EN to add the registered out_zero flag.
module rot_merge
    import rot_merge_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WORD_W-1:0]  ob,
    input  logic [WORD_W-1:0]  a,
    input  logic [SHIFT_W-1:0] sr,
    input  logic [WORD_W-1:0]  msk,
    output logic               out_valid,
    input  logic               out_ready,
`ifdef ROT_MERGE_ZERO_EN
    output logic               out_zero,
`endif
    output logic [WORD_W-1:0]  out_data
);

    s1_t               s1_q, s1_d;
    logic              s2_vld_q, s2_vld_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              rdy_q;

    logic [WORD_W-1:0] rot_w;
    logic [WORD_W-1:0] merged;
    logic              s2_adv;
    logic              s1_adv;
    logic              accept;
    logic              ld;

    rot_merge_rotator u_rot (
        .data_i  (ob),
        .shamt_i (sr),
        .data_o  (rot_w)
    );

    assign merged = merge(s1_q);
    assign s2_adv = ~s2_vld_q | out_ready;
    assign s1_adv = ~s1_q.valid | s2_adv;

    // rdy_q keeps in_ready low until the first edge after reset.
    assign in_ready = rdy_q & ~flush & s1_adv;
    assign accept   = in_valid & in_ready;
    assign ld       = ~flush & s2_adv & s1_q.valid;

    always_comb begin
        s1_d     = s1_q;
        s2_vld_d = s2_vld_q;
        data_d   = data_q;
        if (flush) begin
            s1_d.valid = 1'b0;
            s2_vld_d   = 1'b0;
        end else begin
            if (s2_adv) begin
                s2_vld_d = s1_q.valid;
            end
            if (ld) begin
                data_d = merged;
            end
            if (s1_adv) begin
                s1_d.valid = accept;
                if (accept) begin
                    s1_d.rot = rot_w;
                    s1_d.a   = a;
                    s1_d.msk = msk;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q     <= '0;
            s2_vld_q <= 1'b0;
            data_q   <= '0;
            rdy_q    <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s2_vld_q <= s2_vld_d;
            data_q   <= data_d;
            rdy_q    <= 1'b1;
        end
    end

`ifdef ROT_MERGE_ZERO_EN
    logic zero_q, zero_d;

    assign zero_d = ld ? ~|merged : zero_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            zero_q <= 1'b0;
        end else begin
            zero_q <= zero_d;
        end
    end

    assign out_zero = zero_q;
`endif

    assign out_valid = s2_vld_q;
    assign out_data  = data_q;

endmodule

// File: tb/tb_rot_merge.sv
// Scoreboard bench for rot_merge: random traffic plus directed corner cases.
// Honours ROT_MERGE_ZERO_EN when defined.
module tb_rot_merge;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] ob;
    logic [31:0] a;
    logic [4:0]  sr;
    logic [31:0] msk;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
`ifdef ROT_MERGE_ZERO_EN
    logic        out_zero;
`endif

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    rot_merge dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ob        (ob),
        .a         (a),
        .sr        (sr),
        .msk       (msk),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef ROT_MERGE_ZERO_EN
        .out_zero  (out_zero),
`endif
        .out_data  (out_data)
    );

    // Reference: rotate via a doubled word, then bitwise select.
    function automatic logic [31:0] model(input logic [31:0] o,
                                          input logic [31:0] aa,
                                          input logic [4:0]  s,
                                          input logic [31:0] m);
        logic [63:0] d;
        logic [31:0] r;
        d = {o, o};
        d = d << s;
        r = d[63:32];
        return (r & m) | (aa & ~m);
    endfunction

    task automatic chk32(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [31:0] o,
                       input logic [31:0] aa, input logic [4:0] s,
                       input logic [31:0] m, input logic ordy,
                       input logic fl);
        @(negedge clk);
        in_valid  = v;
        ob        = o;
        a         = aa;
        sr        = s;
        msk       = m;
        out_ready = ordy;
        flush     = fl;
        #1;
        if (v && in_ready) exp_q.push_back(model(o, aa, s, m));
    endtask

    task automatic idle(input logic ordy);
        cyc(1'b0, 32'h0, 32'h0, 5'd0, 32'h0, ordy, 1'b0);
    endtask

    task automatic op_latency(input logic [31:0] o, input logic [31:0] aa,
                              input logic [4:0] s, input logic [31:0] m,
                              input logic [31:0] exp);
        cyc(1'b1, o, aa, s, m, 1'b1, 1'b0);
        chk1("lat_accept", in_ready, 1'b1);
        idle(1'b1);
        chk1("lat_early", out_valid, 1'b0);
        idle(1'b1);
        chk1("lat_valid", out_valid, 1'b1);
        chk32("lat_data", out_data, exp);
`ifdef ROT_MERGE_ZERO_EN
        chk1("lat_zero", out_zero, exp == 32'h0);
`endif
        idle(1'b1);
    endtask

    // Monitor: pops the scoreboard on every consumed result.
    initial begin
        logic        prev_hold;
        logic [31:0] prev_data;
        prev_hold = 1'b0;
        prev_data = 32'h0;
        forever begin
            @(negedge clk);
            #2;
            if (!reset_n) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    chk1("hold_valid", out_valid, 1'b1);
                    chk32("hold_data", out_data, prev_data);
                end
                if (flush) begin
                    exp_q.delete();
                end else if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL sb_extra: got %h expected none",
                                 out_data);
                    end else begin
                        chk32("sb_data", out_data, exp_q.pop_front());
                    end
`ifdef ROT_MERGE_ZERO_EN
                    chk1("sb_zero", out_zero, out_data == 32'h0);
`endif
                end
                prev_hold = out_valid && !out_ready && !flush;
                prev_data = out_data;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int quiet;
        reset_n   = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ob        = '0;
        a         = '0;
        sr        = '0;
        msk       = '0;
        #1 reset_n = 1'b0;
        #1;
        chk1("rst_out_valid", out_valid, 1'b0);
        chk32("rst_out_data", out_data, 32'h0);
        chk1("rst_in_ready", in_ready, 1'b0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk1("rst_rel_ready", in_ready, 1'b0);
        idle(1'b1);
        chk1("post_rst_ready", in_ready, 1'b1);

        op_latency(32'h000000FF, 32'h12345678, 5'd8, 32'h0000FF00,
                   32'h1234FF78);
        op_latency(32'h80000001, 32'h0, 5'd1, 32'hFFFFFFFF, 32'h00000003);
        op_latency(32'hDEADBEEF, 32'hCAFEF00D, 5'd0, 32'h0, 32'hCAFEF00D);
        op_latency(32'hFFFFFFFF, 32'h0, 5'd3, 32'h0, 32'h0);
        op_latency(32'h1, 32'h0, 5'd0, 32'h1, 32'h1);

        // Backpressure: third op must stall until out_ready returns.
        cyc(1'b1, 32'h11111111, 32'h0, 5'd4, 32'hFFFF0000, 1'b0, 1'b0);
        chk1("bp_rdy1", in_ready, 1'b1);
        cyc(1'b1, 32'h22222222, 32'hAAAAAAAA, 5'd31, 32'h00FF00FF, 1'b0, 1'b0);
        chk1("bp_rdy2", in_ready, 1'b1);
        cyc(1'b1, 32'h33333333, 32'h55555555, 5'd17, 32'h0F0F0F0F, 1'b0, 1'b0);
        chk1("bp_rdy3", in_ready, 1'b0);
        cyc(1'b1, 32'h33333333, 32'h55555555, 5'd17, 32'h0F0F0F0F, 1'b1, 1'b0);
        chk1("bp_rdy4", in_ready, 1'b1);
        chk1("bp_out1", out_valid, 1'b1);
        idle(1'b1);
        chk1("bp_out2", out_valid, 1'b1);
        idle(1'b1);
        chk1("bp_out3", out_valid, 1'b1);
        idle(1'b1);
        chk32("bp_drained", 32'(exp_q.size()), 32'd0);
        chk1("bp_idle", out_valid, 1'b0);

        // Asynchronous reset with both stages occupied.
        cyc(1'b1, 32'hA5A5A5A5, 32'h1, 5'd2, 32'hF0F0F0F0, 1'b0, 1'b0);
        cyc(1'b1, 32'h5A5A5A5A, 32'h2, 5'd9, 32'h0FF00FF0, 1'b0, 1'b0);
        idle(1'b0);
        chk1("mid_full", out_valid, 1'b1);
        reset_n = 1'b0;
        #1;
        chk1("mid_rst_valid", out_valid, 1'b0);
        chk32("mid_rst_data", out_data, 32'h0);
        chk1("mid_rst_ready", in_ready, 1'b0);
`ifdef ROT_MERGE_ZERO_EN
        chk1("mid_rst_zero", out_zero, 1'b0);
`endif
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        quiet = 0;
        for (int i = 0; i < 6; i++) begin
            idle(1'b1);
            if (out_valid) quiet++;
        end
        chk32("post_rst_quiet", 32'(quiet), 32'd0);

        // Flush with both stages full and a simultaneous offer.
        cyc(1'b1, 32'h0F0F0F0F, 32'h3, 5'd5, 32'hFFFFFFFF, 1'b0, 1'b0);
        cyc(1'b1, 32'hF0F0F0F0, 32'h4, 5'd6, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, 32'h12121212, 32'h5, 5'd7, 32'h1, 1'b1, 1'b1);
        chk1("flush_ready", in_ready, 1'b0);
        idle(1'b1);
        chk1("flush_valid", out_valid, 1'b0);
        idle(1'b1);
        chk1("flush_empty", out_valid, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 10) < 7, $urandom, $urandom,
                5'($urandom_range(0, 31)), $urandom,
                ($urandom % 10) < 6, ($urandom % 97) == 0);
        end
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            idle(1'b1);
        end
        idle(1'b1);
        chk32("final_drain", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
